// File: rtl/wbu_regf_writer.sv
// wbu_regf_writer: write-back unit for the integer register file.
// Arbitrates EXU and LSU results (round-robin on ties) into one registered
// write per cycle, and tracks registers with writes in flight for IDU stalls.
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_idu_issue/rd/rd_wen            IDU dispatch, marks rd as pending
//   i_idu_rs1_addr/rs2_addr          sources of the instruction in decode
//   o_raw_stall, o_waw_stall         hazard stalls from the pending set
//   i_exu_valid/rd/data, o_exu_ready EXU result channel
//   i_lsu_valid/rd/data, o_lsu_ready LSU result channel
//   o_wbu_en/waddr/wdata             register file write port
//   o_busy                           pending-write scoreboard, bit 0 always 0

`ifndef REG_NUM
`define REG_NUM 16
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef CPU_ADDR
`define CPU_ADDR 4
`endif

module wbu_regf_writer #(
    parameter int unsigned REG_NUM   = `REG_NUM,
    parameter int unsigned CPU_WIDTH = `CPU_WIDTH,
    parameter int unsigned CPU_ADDR  = `CPU_ADDR
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_idu_issue,
    input  logic [CPU_ADDR-1:0]  i_idu_rd,
    input  logic                 i_idu_rd_wen,
    input  logic [CPU_ADDR-1:0]  i_idu_rs1_addr,
    input  logic [CPU_ADDR-1:0]  i_idu_rs2_addr,
    output logic                 o_raw_stall,
    output logic                 o_waw_stall,
    input  logic                 i_exu_valid,
    output logic                 o_exu_ready,
    input  logic [CPU_ADDR-1:0]  i_exu_rd,
    input  logic [CPU_WIDTH-1:0] i_exu_data,
    input  logic                 i_lsu_valid,
    output logic                 o_lsu_ready,
    input  logic [CPU_ADDR-1:0]  i_lsu_rd,
    input  logic [CPU_WIDTH-1:0] i_lsu_data,
    output logic                 o_wbu_en,
    output logic [CPU_ADDR-1:0]  o_wbu_waddr,
    output logic [CPU_WIDTH-1:0] o_wbu_wdata,
    output logic [REG_NUM-1:0]   o_busy
);

    // High when the LSU received the most recent grant; reset favours LSU on the first tie.
    logic               last_lsu;
    logic               exu_grant;
    logic               lsu_grant;
    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] clr_mask;

    // Grant is pure function of the valids: the write port drains every cycle.
    always_comb begin
        exu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!i_rst) begin
            if (i_exu_valid && i_lsu_valid) begin
                exu_grant = last_lsu;
                lsu_grant = !last_lsu;
            end else begin
                exu_grant = i_exu_valid;
                lsu_grant = i_lsu_valid;
            end
        end
    end

    assign o_exu_ready = exu_grant;
    assign o_lsu_ready = lsu_grant;

    // Hazard stalls against the registered pending set; x0 never stalls.
    assign o_raw_stall = ((i_idu_rs1_addr != '0) && o_busy[i_idu_rs1_addr])
                      || ((i_idu_rs2_addr != '0) && o_busy[i_idu_rs2_addr]);
    assign o_waw_stall = i_idu_rd_wen && (i_idu_rd != '0) && o_busy[i_idu_rd];

    // Per-register set (issue) and clear (write on the port) masks; bit 0 stays clear.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int unsigned r = 1; r < REG_NUM; r++) begin
            set_mask[r] = i_idu_issue && i_idu_rd_wen && (i_idu_rd == CPU_ADDR'(r));
            clr_mask[r] = o_wbu_en && (o_wbu_waddr == CPU_ADDR'(r));
        end
    end

    // Scoreboard: set is applied after clear so a same-cycle collision keeps the bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_busy <= '0;
        end else begin
            o_busy <= (o_busy & ~clr_mask) | set_mask;
        end
    end

    // Output write register; a result to x0 is consumed without a write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wbu_en    <= 1'b0;
            o_wbu_waddr <= '0;
            o_wbu_wdata <= '0;
            last_lsu    <= 1'b0;
        end else if (exu_grant) begin
            o_wbu_en    <= (i_exu_rd != '0);
            o_wbu_waddr <= i_exu_rd;
            o_wbu_wdata <= i_exu_data;
            last_lsu    <= 1'b0;
        end else if (lsu_grant) begin
            o_wbu_en    <= (i_lsu_rd != '0);
            o_wbu_waddr <= i_lsu_rd;
            o_wbu_wdata <= i_lsu_data;
            last_lsu    <= 1'b1;
        end else begin
            o_wbu_en    <= 1'b0;
        end
    end

endmodule
